// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote, start/stop validation.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             rx_sync_p0;
    logic             rx_sync_p1;
    logic [2:0]       hist_p2;
    logic [7:0]       shift_p2;
    logic             sampled;
    logic             bit_end;

    function automatic logic majority3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

    assign sampled = majority3(hist_p2);
    assign bit_end = (cnt == CNT_LAST);

    // Stage p0/p1: metastability guard; p2: sample history for the vote
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            hist_p2    <= 3'b111;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
            hist_p2    <= {hist_p2[1:0], rx_sync_p1};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (state == DATA && bit_end)
            shift_p2 <= {sampled, shift_p2[7:1]};
        if (state == PARITY && bit_end)
            par_bit <= sampled;
    end
`else
    always_ff @(posedge clk) begin
        if (state == DATA && bit_end)
            shift_p2 <= {sampled, shift_p2[7:1]};
    end

    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            data_out  <= 8'h00;
            rx_done   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    busy    <= 1'b0;
                    if (!rx_sync_p1) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is high again by mid-bit was only a glitch
                        if (sampled) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        // Leaving at mid-stop leaves half a bit to catch a back-to-back start
                        if (sampled) begin
                            data_out <= shift_p2;
                            rx_done  <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
`ifdef UART_RX_PARITY_EN
                            parity_err <= ^{shift_p2, par_bit};
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    // Hold off until the line idles so a break cannot retrigger
                    if (rx_sync_p1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLKS_PER_BIT = 16; honours UART_RX_PARITY_EN.
module tb_uart_receiver;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 156 + CPB;
`else
    localparam int LAT = 156;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .busy      (busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, perr_with_done = 0, overlap = 0;
    int done_cyc = 0, start_cyc = 0, busy_gap = 0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            done_cyc = cyc;
            got_q.push_back(data_out);
        end
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (parity_err && rx_done) perr_with_done++;
        if (rx_done && frame_err) overlap++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish by itself");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b, input bit chk);
        rx = b;
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            if (chk && !busy) busy_gap++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b1);
`ifdef UART_RX_PARITY_EN
        send_bit(^d, 1'b1);
`endif
        send_bit(stop, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx  = 1'b1;
        #100;
        total++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (rx_done !== 1'b0) $display("FAIL reset_rx_done: got %b want 0", rx_done); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
        total++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", parity_err); else passed++;
        total++; if (data_out !== 8'h00 || busy !== 1'b0) $display("FAIL post_reset_idle: data_out %h busy %b want 00/0", data_out, busy); else passed++;
    endtask

    task automatic test_single_frame;
        int d0, f0, lat;
        d0 = done_cnt; f0 = ferr_cnt; busy_gap = 0;
        send_frame(8'hAA, 1'b1);
        repeat (4) @(negedge clk);
        lat = done_cyc - start_cyc;
        total++; if (done_cnt - d0 !== 1) $display("FAIL aa_done_count: got %0d want 1", done_cnt - d0); else passed++;
        total++; if (data_out !== 8'hAA) $display("FAIL aa_data: got %h want aa", data_out); else passed++;
        total++; if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL aa_latency: got %0d want %0d +-1", lat, LAT); else passed++;
        total++; if (busy_gap !== 0) $display("FAIL aa_busy_held: got %0d low cycles want 0", busy_gap); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL aa_busy_after: got %b want 0", busy); else passed++;
        total++; if (ferr_cnt - f0 !== 0) $display("FAIL aa_frame_err: got %0d want 0", ferr_cnt - f0); else passed++;
    endtask

    task automatic test_glitch;
        int d0, f0;
        logic saw_busy, busy_mid;
        d0 = done_cnt; f0 = ferr_cnt; saw_busy = 1'b0; busy_mid = 1'bx;
        rx = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 4) rx = 1'b1;
            if (busy) saw_busy = 1'b1;
            if (i == 14) busy_mid = busy;
        end
        repeat (180) @(negedge clk);
        total++; if (saw_busy !== 1'b1) $display("FAIL glitch_busy_pulse: got %b want 1", saw_busy); else passed++;
        total++; if (busy_mid !== 1'b0) $display("FAIL glitch_busy_drop: got %b want 0", busy_mid); else passed++;
        total++; if (done_cnt - d0 !== 0) $display("FAIL glitch_no_done: got %0d want 0", done_cnt - d0); else passed++;
        total++; if (ferr_cnt - f0 !== 0) $display("FAIL glitch_no_ferr: got %0d want 0", ferr_cnt - f0); else passed++;
        total++; if (data_out !== 8'hAA) $display("FAIL glitch_data_kept: got %h want aa", data_out); else passed++;
    endtask

    task automatic test_frame_error;
        int d0, f0, busy_hi;
        d0 = done_cnt; f0 = ferr_cnt; busy_gap = 0; busy_hi = 0;
        send_frame(8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        total++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_pulse: got %0d want 1", ferr_cnt - f0); else passed++;
        total++; if (busy_gap !== 0) $display("FAIL ferr_busy_in_break: got %0d low cycles want 0", busy_gap); else passed++;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL ferr_busy_release: got %b want 0", busy); else passed++;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        total++; if (busy_hi !== 0) $display("FAIL ferr_no_retrigger: got %0d busy cycles want 0", busy_hi); else passed++;
        total++; if (done_cnt - d0 !== 0) $display("FAIL ferr_no_done: got %0d want 0", done_cnt - d0); else passed++;
        total++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_single: got %0d want 1", ferr_cnt - f0); else passed++;
        total++; if (data_out !== 8'hAA) $display("FAIL ferr_data_kept: got %h want aa", data_out); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] first, second;
        got_q.delete();
        send_frame(8'h55, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (10) @(negedge clk);
        first  = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        second = (got_q.size() > 1) ? got_q[1] : 8'hxx;
        total++; if (got_q.size() !== 2) $display("FAIL b2b_count: got %0d want 2", got_q.size()); else passed++;
        total++; if (first !== 8'h55) $display("FAIL b2b_first: got %h want 55", first); else passed++;
        total++; if (second !== 8'hFF) $display("FAIL b2b_second: got %h want ff", second); else passed++;
    endtask

    task automatic test_reset_abort;
        int d0;
        d0 = done_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if (data_out !== 8'h00) $display("FAIL abort_async_data: got %h want 00", data_out); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_async_busy: got %b want 0", busy); else passed++;
        total++; if (rx_done !== 1'b0 || frame_err !== 1'b0) $display("FAIL abort_async_strobes: got %b%b want 00", rx_done, frame_err); else passed++;
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (200) @(negedge clk);
        total++; if (done_cnt - d0 !== 0) $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); else passed++;
        total++; if (data_out !== 8'h00) $display("FAIL abort_data_after: got %h want 00", data_out); else passed++;
        send_frame(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        total++; if (done_cnt - d0 !== 1) $display("FAIL abort_next_done: got %0d want 1", done_cnt - d0); else passed++;
        total++; if (data_out !== 8'h81) $display("FAIL abort_next_data: got %h want 81", data_out); else passed++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b1);
        send_bit(par, 1'b1);
        send_bit(1'b1, 1'b0);
    endtask

    task automatic test_parity;
        int d0, p0, c0;
        d0 = done_cnt; p0 = perr_cnt; c0 = perr_with_done;
        send_frame_par(8'h07, 1'b1);
        repeat (10) @(negedge clk);
        total++; if (done_cnt - d0 !== 1) $display("FAIL par_good_done: got %0d want 1", done_cnt - d0); else passed++;
        total++; if (perr_cnt - p0 !== 0) $display("FAIL par_good_perr: got %0d want 0", perr_cnt - p0); else passed++;
        send_frame_par(8'h07, 1'b0);
        repeat (10) @(negedge clk);
        total++; if (done_cnt - d0 !== 2) $display("FAIL par_bad_done: got %0d want 2", done_cnt - d0); else passed++;
        total++; if (perr_with_done - c0 !== 1) $display("FAIL par_bad_coincident: got %0d want 1", perr_with_done - c0); else passed++;
        total++; if (perr_cnt - p0 !== 1) $display("FAIL par_bad_single: got %0d want 1", perr_cnt - p0); else passed++;
        total++; if (data_out !== 8'h07) $display("FAIL par_bad_data: got %h want 07", data_out); else passed++;
    endtask
`else
    task automatic test_parity;
        total++; if (perr_cnt !== 0) $display("FAIL parity_tied_low: got %0d pulses want 0", perr_cnt); else passed++;
    endtask
`endif

    task automatic test_no_overlap;
        total++; if (overlap !== 0) $display("FAIL done_ferr_overlap: got %0d want 0", overlap); else passed++;
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_glitch;
        test_frame_error;
        test_back_to_back;
        test_reset_abort;
        test_parity;
        test_no_overlap;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
